// File: rtl/gun_pkg.sv
// Shared constants for the light-gun crosshair generator.
// Covers joystick bit positions, axis FSM encoding and the arithmetic headroom.
package gun_pkg;
  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  // Extra bits above POS_W so that a step past either bound cannot wrap before saturation.
  localparam int ARITH_PAD = 4;

  typedef logic [0:0] axis_state_t;
  localparam axis_state_t AX_IDLE = 1'b0;
  localparam axis_state_t AX_MOVE = 1'b1;
endpackage

// File: rtl/gun_axis.sv
// One bounded crosshair axis.
// Handles digital moves with tick-paced acceleration, saturation at the bounds, and the absolute analog map.
module gun_axis
  import gun_pkg::*;
#(
  parameter int POS_W      = 6,
  parameter int MIN        = 0,
  parameter int MAX        = 63,
  parameter int CTR        = 32,
  parameter int ACC_LEVELS = 4,
  parameter int ACC_HOLD   = 8,
  parameter bit ANA_NEG    = 1'b0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             srst,
  input  logic             tick,
  input  logic             recenter,
  input  logic             analog_en,
  input  logic             dir_inc,
  input  logic             dir_dec,
  input  logic [7:0]       ana,
  output logic [POS_W-1:0] pos,
  output logic             chg
);
  localparam int AW     = POS_W + ARITH_PAD;
  localparam int LVL_W  = (ACC_LEVELS > 1) ? $clog2(ACC_LEVELS) : 1;
  localparam int HOLD_W = (ACC_HOLD > 1) ? $clog2(ACC_HOLD) : 1;
  localparam logic signed [AW-1:0] LO_S = AW'(MIN);
  localparam logic signed [AW-1:0] HI_S = AW'(MAX);

  axis_state_t       state_r, state_nxt_s;
  logic [LVL_W-1:0]  lvl_r, lvl_nxt_s, eff_lvl_s;
  logic [HOLD_W-1:0] hold_r, hold_nxt_s, eff_hold_s;
  logic              dir_r, dir_nxt_s;
  logic [POS_W-1:0]  pos_r, pos_nxt_s, sat_pos_s, ana_pos_s;
  logic              one_s, same_dir_s;
  logic signed [AW-1:0] cur_s, step_s, sum_s;
  logic signed [8:0] ana_ext_s, ana_neg_s;
  logic [7:0]        ana_sel_s, ana_off_s;
  logic [16:0]       prod_s;

  // Candidate digital step: continue the current run, or restart at level 0 on entry/reversal.
  always_comb begin
    one_s      = dir_inc ^ dir_dec;
    same_dir_s = (state_r == AX_MOVE) && (dir_r == dir_inc);
    eff_lvl_s  = same_dir_s ? lvl_r : {LVL_W{1'b0}};
    eff_hold_s = same_dir_s ? hold_r : {HOLD_W{1'b0}};
    cur_s      = signed'(AW'(pos_r));
    step_s     = signed'(AW'(1'b1) << eff_lvl_s);
    sum_s      = dir_inc ? (cur_s + step_s) : (cur_s - step_s);
    if (sum_s < LO_S) begin
      sat_pos_s = POS_W'(MIN);
    end else if (sum_s > HI_S) begin
      sat_pos_s = POS_W'(MAX);
    end else begin
      sat_pos_s = sum_s[POS_W-1:0];
    end
  end

  // Absolute analog map; the vertical axis inverts the stick and clamps -(-128) to 127.
  always_comb begin
    ana_ext_s = signed'({ana[7], ana});
    ana_neg_s = -ana_ext_s;
    if (ANA_NEG) begin
      ana_sel_s = (ana_neg_s > 9'sd127) ? 8'h7F : ana_neg_s[7:0];
    end else begin
      ana_sel_s = ana;
    end
    ana_off_s = {~ana_sel_s[7], ana_sel_s[6:0]};
    prod_s    = 17'(ana_off_s) * 17'(MAX - MIN + 1);
    ana_pos_s = POS_W'(17'(MIN) + (prod_s >> 8));
  end

  // Next-state selection; recenter beats analog, analog beats digital motion.
  always_comb begin
    state_nxt_s = state_r;
    lvl_nxt_s   = lvl_r;
    hold_nxt_s  = hold_r;
    dir_nxt_s   = dir_r;
    pos_nxt_s   = pos_r;
    if (recenter) begin
      pos_nxt_s   = POS_W'(CTR);
      state_nxt_s = AX_IDLE;
      lvl_nxt_s   = {LVL_W{1'b0}};
      hold_nxt_s  = {HOLD_W{1'b0}};
    end else if (analog_en) begin
      state_nxt_s = AX_IDLE;
      lvl_nxt_s   = {LVL_W{1'b0}};
      hold_nxt_s  = {HOLD_W{1'b0}};
      if (tick) begin
        pos_nxt_s = ana_pos_s;
      end else begin
        pos_nxt_s = pos_r;
      end
    end else if (tick && one_s) begin
      state_nxt_s = AX_MOVE;
      dir_nxt_s   = dir_inc;
      pos_nxt_s   = sat_pos_s;
      if (eff_hold_s == HOLD_W'(ACC_HOLD - 1)) begin
        hold_nxt_s = {HOLD_W{1'b0}};
        lvl_nxt_s  = (eff_lvl_s == LVL_W'(ACC_LEVELS - 1)) ? eff_lvl_s : eff_lvl_s + LVL_W'(1);
      end else begin
        hold_nxt_s = eff_hold_s + HOLD_W'(1);
        lvl_nxt_s  = eff_lvl_s;
      end
    end else if (tick) begin
      state_nxt_s = AX_IDLE;
      lvl_nxt_s   = {LVL_W{1'b0}};
      hold_nxt_s  = {HOLD_W{1'b0}};
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= AX_IDLE;
      lvl_r   <= {LVL_W{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      dir_r   <= 1'b0;
      pos_r   <= POS_W'(CTR);
    end else if (srst) begin
      state_r <= AX_IDLE;
      lvl_r   <= {LVL_W{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      dir_r   <= 1'b0;
      pos_r   <= POS_W'(CTR);
    end else begin
      state_r <= state_nxt_s;
      lvl_r   <= lvl_nxt_s;
      hold_r  <= hold_nxt_s;
      dir_r   <= dir_nxt_s;
      pos_r   <= pos_nxt_s;
    end
  end

  assign pos = pos_r;
  assign chg = (pos_nxt_s != pos_r);
endmodule

// File: rtl/gun_position_ctrl.sv
// Multi-player light-gun crosshair generator.
// Instantiates one H and one V axis per player, slices the buses and registers the per-player moving flag.
module gun_position_ctrl
  import gun_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 6,
  parameter int H_MIN       = 0,
  parameter int H_MAX       = 63,
  parameter int V_MIN       = 0,
  parameter int V_MAX       = 63,
  parameter int H_CTR       = 32,
  parameter int V_CTR       = 32,
  parameter int ACC_LEVELS  = 4,
  parameter int ACC_HOLD    = 8
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         srst,
  input  logic                         tick,
  input  logic [4*NUM_PLAYERS-1:0]     joy_dir,
  input  logic [NUM_PLAYERS-1:0]       analog_en,
  input  logic [8*NUM_PLAYERS-1:0]     ana_x,
  input  logic [8*NUM_PLAYERS-1:0]     ana_y,
  input  logic [NUM_PLAYERS-1:0]       recenter,
  output logic [POS_W*NUM_PLAYERS-1:0] gun_h,
  output logic [POS_W*NUM_PLAYERS-1:0] gun_v,
  output logic [NUM_PLAYERS-1:0]       moving
);
  logic [NUM_PLAYERS-1:0] chg_h_s, chg_v_s, moving_nxt_s, moving_r;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    gun_axis #(
      .POS_W(POS_W), .MIN(H_MIN), .MAX(H_MAX), .CTR(H_CTR),
      .ACC_LEVELS(ACC_LEVELS), .ACC_HOLD(ACC_HOLD), .ANA_NEG(1'b0)
    ) u_axis_h (
      .clk_sys(clk_sys), .reset_n(reset_n), .srst(srst), .tick(tick),
      .recenter(recenter[p]), .analog_en(analog_en[p]),
      .dir_inc(joy_dir[4*p+DIR_RIGHT]), .dir_dec(joy_dir[4*p+DIR_LEFT]),
      .ana(ana_x[8*p +: 8]), .pos(gun_h[POS_W*p +: POS_W]), .chg(chg_h_s[p])
    );

    // Up raises V so that digital motion agrees with the inverted analog Y map.
    gun_axis #(
      .POS_W(POS_W), .MIN(V_MIN), .MAX(V_MAX), .CTR(V_CTR),
      .ACC_LEVELS(ACC_LEVELS), .ACC_HOLD(ACC_HOLD), .ANA_NEG(1'b1)
    ) u_axis_v (
      .clk_sys(clk_sys), .reset_n(reset_n), .srst(srst), .tick(tick),
      .recenter(recenter[p]), .analog_en(analog_en[p]),
      .dir_inc(joy_dir[4*p+DIR_UP]), .dir_dec(joy_dir[4*p+DIR_DOWN]),
      .ana(ana_y[8*p +: 8]), .pos(gun_v[POS_W*p +: POS_W]), .chg(chg_v_s[p])
    );
  end

  // Moving flag: refreshed on every tick, cleared by recenter, held otherwise.
  always_comb begin
    moving_nxt_s = moving_r;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (recenter[p]) begin
        moving_nxt_s[p] = 1'b0;
      end else if (tick) begin
        moving_nxt_s[p] = chg_h_s[p] | chg_v_s[p];
      end else begin
        moving_nxt_s[p] = moving_r[p];
      end
    end
  end

  // Moving flag register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      moving_r <= {NUM_PLAYERS{1'b0}};
    end else if (srst) begin
      moving_r <= {NUM_PLAYERS{1'b0}};
    end else begin
      moving_r <= moving_nxt_s;
    end
  end

  assign moving = moving_r;
endmodule
